mlab_fifo_ctrl: RTL and testbench
=================================

Name: mlab_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences one 32x20 MLAB storage slice.
- Owns the write and read pointers, occupancy and flags.
- Drives the slice's write-enable, write address and read address.
- Presents a show-ahead valid/pop interface to the consumer, accounting for the slice's 2-stage write pipeline and registered read output.
- Collects the slice's parity-check result into a sticky error flag.

Parameters:
ADDR_WIDTH, 5, slice address width; DEPTH = 2**ADDR_WIDTH = 32 entries
WR_LAT, 3, cycles from accepted push until that entry is readable via the read address
RD_LAT, 1, cycles from read address to slice data output (registered read); fixed at 1

Ports:
clk  in  1  single clock (slice din_clk and dout_clk both tied to it)
sclr  in  1  synchronous active-high reset
push  in  1  producer write request; data goes to the slice din directly this cycle
in_ready  out  1  not full; a push counts only when in_ready=1
mem_we  out  1  to slice we; equals push & in_ready (combinational)
mem_wraddr  out  ADDR_WIDTH  to slice wraddr; current write pointer
mem_rdaddr  out  ADDR_WIDTH  to slice rdaddr; combinational, see Behaviour
out_valid  out  1  slice dout holds head entry
pop  in  1  consumer takes head; effective only when out_valid=1
used_words  out  ADDR_WIDTH+1  allocated entries, 0..DEPTH
full  out  1  used_words==DEPTH
empty  out  1  used_words==0
parity_err_in  in  1  slice parity_err_out
parity_err  out  1  sticky: parity error seen on a popped word
overflow  out  1  sticky: push while full
underflow  out  1  sticky: pop while !out_valid

Behaviour:
- Reset (sclr=1 at an edge) clears:
  - wr_ptr, rd_ptr, used_words, avail, commit shift register;
  - out_valid, parity_err, overflow, underflow.
- After reset: in_ready=1, empty=1, full=0.
- mem_we is 0 while sclr is high.
- Writes already inside the slice's input pipeline at reset may still land in memory. They are ignored, because the pointers are cleared.
- Push accept (push & !full): mem_we=1, mem_wraddr=wr_ptr; wr_ptr wraps 31->0; used_words +1.
- Commit: each accepted push enters a WR_LAT-deep shift register. Its exit increments avail (count of readable, unpopped entries, 0..32).
- Pop accept (pop & out_valid): rd_ptr +1 (wraps), used_words -1, avail -1.
- Simultaneous push accept and pop accept: used_words unchanged. Commit exit with pop in the same cycle: avail unchanged.
- mem_rdaddr = pop accept ? rd_ptr+1 : rd_ptr. The slice registers its output, so the next cycle's dout is the new head.
- out_valid is registered: out_valid <= (avail_next > 0), where avail_next includes this cycle's commit and pop.
  - A stalled head keeps the same rdaddr, so the slice output is stable.
  - The head slot is not reusable until popped, so it cannot be overwritten.
- Latency: push accepted in cycle 0 into an empty FIFO gives out_valid=1 from cycle WR_LAT+1 = 4.
- Back-to-back pops with avail>1 sustain 1 word/cycle with no bubble.
- Full: in_ready=!full uses registered occupancy only. A pop in the same cycle does not admit a push.
  - push while full: write suppressed, overflow set.
- Empty: pop with out_valid=0 has no pointer or count change; underflow set.
- used_words counts allocated entries, including uncommitted ones. empty=1 does not imply out_valid=1 soon, nor the reverse after pushes.
- Parity: parity_err is set when parity_err_in=1 in a cycle with pop accept. It is held until sclr.
  - The slice's parity chain input is tied 0 by the integrator.
- Arithmetic: pointers are ADDR_WIDTH bits with natural wrap; counters are ADDR_WIDTH+1 bits and never exceed DEPTH.

Decomposition:
- Shared package mlab_fifo_pkg holds ADDR_WIDTH, DEPTH, WR_LAT, RD_LAT and the slice width constant (20).
- One sub-module: mlab_fifo_commit_dly, a WR_LAT-stage 1-bit shift register with sync clear. It produces the commit pulse.

Test Plan:
- Reset then single push at cycle 0, pop held 0 -> mem_wraddr=0, out_valid rises at cycle 4, used_words=1, empty=0; pop at cycle 5 -> out_valid=0 at cycle 6, empty=1.
- 32 consecutive pushes -> full=1 and in_ready=0 after 32nd; 33rd push -> no mem_we, overflow=1; wr_ptr wraps to 0.
- Full FIFO with push and pop in the same cycle -> push rejected, used_words 31, next push accepted with mem_wraddr=0.
- Stream 100 words: push every cycle, pop whenever out_valid -> pops continuous after fill, mem_rdaddr sequence 0..31,0.., data order preserved (scoreboard against slice model), no overflow or underflow.
- Pop with out_valid=0 right after reset -> underflow=1, rd_ptr=0, used_words=0.
- parity_err_in=1 on a pop-accept cycle -> parity_err=1 and held; parity_err_in=1 without pop -> no change; sclr mid-stream with 10 entries -> all counters 0 and out_valid=0 next cycle.

Source files
------------

// File: rtl/mlab_fifo_pkg.sv
// Shared constants and types for the MLAB-slice FIFO controller.
package mlab_fifo_pkg;

  // Slice geometry and timing
  localparam int ADDR_WIDTH  = 5;
  localparam int DEPTH       = 1 << ADDR_WIDTH;
  localparam int WR_LAT      = 3;   // accepted push -> entry readable via rdaddr
  localparam int RD_LAT      = 1;   // registered slice read output
  localparam int SLICE_WIDTH = 20;  // data width of the storage slice

  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [ADDR_WIDTH:0]   cnt_t;

  localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

  // Sticky error flags reported to the host
  typedef struct packed {
    logic parity;
    logic overflow;
    logic underflow;
  } err_flags_t;

  // Pointer advance with natural power-of-two wrap
  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/mlab_fifo_commit_dly.sv
// Delay line that turns an accepted push into a commit pulse once the
// slice's write pipeline has landed the word in memory.
module mlab_fifo_commit_dly
  import mlab_fifo_pkg::*;
#(
  parameter int STAGES = WR_LAT
) (
  input  logic clk,
  input  logic sclr,
  input  logic in_pulse,
  output logic out_pulse
);

  logic [STAGES-1:0] shift_d;
  logic [STAGES-1:0] shift_q;

  // Next shift contents: new pulse enters stage 0, others move up one
  always_comb begin
    shift_d    = shift_q;
    shift_d[0] = in_pulse;
    for (int i = 1; i < STAGES; i++) begin
      shift_d[i] = shift_q[i-1];
    end
  end

  // Shift register with synchronous clear
  always_ff @(posedge clk) begin
    if (sclr) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign out_pulse = shift_q[STAGES-1];

endmodule

// File: rtl/mlab_fifo_ctrl.sv
// Controller for one 32x20 MLAB storage slice: pointers, occupancy,
// show-ahead output valid, and sticky error flags.
module mlab_fifo_ctrl
  import mlab_fifo_pkg::*;
(
  input  logic                  clk,
  input  logic                  sclr,
  input  logic                  push,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_wraddr,
  output logic [ADDR_WIDTH-1:0] mem_rdaddr,
  output logic                  out_valid,
  input  logic                  pop,
  output logic [ADDR_WIDTH:0]   used_words,
  output logic                  full,
  output logic                  empty,
  input  logic                  parity_err_in,
  output logic                  parity_err,
  output logic                  overflow,
  output logic                  underflow
);

  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       rd_ptr_q, rd_ptr_d;
  cnt_t       used_q, used_d;
  cnt_t       avail_q, avail_d;     // committed, unpopped entries
  logic       out_valid_q, out_valid_d;
  err_flags_t err_q, err_d;

  logic push_acc;
  logic pop_acc;
  logic commit;

  // Flags come from registered occupancy only, so a same-cycle pop never
  // opens room for a push.
  assign full     = (used_q == DEPTH_CNT);
  assign empty    = (used_q == '0);
  assign in_ready = ~full;

  assign push_acc = push & in_ready & ~sclr;
  assign pop_acc  = pop & out_valid_q;

  // Accepted pushes become readable WR_LAT cycles later
  mlab_fifo_commit_dly #(
    .STAGES (WR_LAT)
  ) u_commit_dly (
    .clk       (clk),
    .sclr      (sclr),
    .in_pulse  (push_acc),
    .out_pulse (commit)
  );

  // Next-state for pointers, counters, valid and sticky flags
  always_comb begin
    wr_ptr_d = push_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_acc  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    used_d = used_q;
    case ({push_acc, pop_acc})
      2'b10:   used_d = used_q + cnt_t'(1);
      2'b01:   used_d = used_q - cnt_t'(1);
      default: used_d = used_q;
    endcase

    avail_d = avail_q;
    case ({commit, pop_acc})
      2'b10:   avail_d = avail_q + cnt_t'(1);
      2'b01:   avail_d = avail_q - cnt_t'(1);
      default: avail_d = avail_q;
    endcase

    // Head is valid next cycle whenever anything committed remains
    out_valid_d = (avail_d != '0);

    err_d           = err_q;
    err_d.parity    = err_q.parity    | (parity_err_in & pop_acc);
    err_d.overflow  = err_q.overflow  | (push & full);
    err_d.underflow = err_q.underflow | (pop & ~out_valid_q);
  end

  // State registers with synchronous clear
  always_ff @(posedge clk) begin
    if (sclr) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      used_q      <= '0;
      avail_q     <= '0;
      out_valid_q <= 1'b0;
      err_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      used_q      <= used_d;
      avail_q     <= avail_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  // Slice addressing: look one ahead on a pop so the registered slice
  // output already holds the new head next cycle; a stalled head keeps
  // the same address and therefore a stable output.
  assign mem_we     = push_acc;
  assign mem_wraddr = wr_ptr_q;
  assign mem_rdaddr = pop_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;

  assign out_valid  = out_valid_q;
  assign used_words = used_q;
  assign parity_err = err_q.parity;
  assign overflow   = err_q.overflow;
  assign underflow  = err_q.underflow;

endmodule

// File: tb/tb_mlab_fifo_ctrl.sv
// Self-checking bench for mlab_fifo_ctrl with a behavioural slice model.
module tb_mlab_fifo_ctrl;
  import mlab_fifo_pkg::*;

  logic                   clk = 1'b0;
  logic                   sclr, push, pop, parity_err_in;
  logic                   in_ready, mem_we, out_valid, full, empty;
  logic                   parity_err, overflow, underflow;
  logic [ADDR_WIDTH-1:0]  mem_wraddr, mem_rdaddr;
  logic [ADDR_WIDTH:0]    used_words;
  logic [SLICE_WIDTH-1:0] wdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mlab_fifo_ctrl dut (
    .clk           (clk),
    .sclr          (sclr),
    .push          (push),
    .in_ready      (in_ready),
    .mem_we        (mem_we),
    .mem_wraddr    (mem_wraddr),
    .mem_rdaddr    (mem_rdaddr),
    .out_valid     (out_valid),
    .pop           (pop),
    .used_words    (used_words),
    .full          (full),
    .empty         (empty),
    .parity_err_in (parity_err_in),
    .parity_err    (parity_err),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  // Slice model: two-stage write pipeline, registered read output
  logic                   p1_we = 1'b0, p2_we = 1'b0;
  logic [ADDR_WIDTH-1:0]  p1_a, p2_a;
  logic [SLICE_WIDTH-1:0] p1_d, p2_d;
  logic [SLICE_WIDTH-1:0] slice_mem [DEPTH];
  logic [SLICE_WIDTH-1:0] slice_dout;

  always @(posedge clk) begin
    p1_we <= mem_we;
    p1_a  <= mem_wraddr;
    p1_d  <= wdata;
    p2_we <= p1_we;
    p2_a  <= p1_a;
    p2_d  <= p1_d;
    if (p2_we) slice_mem[p2_a] <= p2_d;
    slice_dout <= slice_mem[mem_rdaddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Inputs change at negedge; outputs are sampled 1 time unit later
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    sclr = 1'b1; push = 1'b0; pop = 1'b0; parity_err_in = 1'b0;
    tick(); tick();
    sclr = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 16 && !out_valid; i++) tick();
    #1;
    chk(name, out_valid, 1);
  endtask

  function automatic logic [SLICE_WIDTH-1:0] word_of(input int k);
    return SLICE_WIDTH'(k * 1031 + 5);
  endfunction

  typedef struct {
    logic push, pop, par;
    logic we;
    int   wraddr, rdaddr;
    logic ov, rdy;
    int   used;
    logic emp, uf, pe;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int popped, pushed, bubbles;
    logic seen_valid;

    //            push pop par  we wa ra  ov rdy used emp uf pe
    vecs[0]  = '{1'b1,1'b0,1'b0, 1'b1,0,0, 1'b0,1'b1,0,1'b1,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b0,1'b0, 1'b0,1,0, 1'b0,1'b1,1,1'b0,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b0, 1'b0,1,0, 1'b0,1'b1,1,1'b0,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b0, 1'b0,1,0, 1'b0,1'b1,1,1'b0,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b0, 1'b0,1,0, 1'b1,1'b1,1,1'b0,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b1,1'b0, 1'b0,1,1, 1'b1,1'b1,1,1'b0,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b0,1'b0, 1'b0,1,1, 1'b0,1'b1,0,1'b1,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b1,1'b0, 1'b0,1,1, 1'b0,1'b1,0,1'b1,1'b0,1'b0};
    vecs[8]  = '{1'b1,1'b0,1'b0, 1'b1,1,1, 1'b0,1'b1,0,1'b1,1'b1,1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b1, 1'b0,2,1, 1'b0,1'b1,1,1'b0,1'b1,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b1, 1'b0,2,1, 1'b0,1'b1,1,1'b0,1'b1,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b1, 1'b0,2,1, 1'b0,1'b1,1,1'b0,1'b1,1'b0};
    vecs[12] = '{1'b0,1'b1,1'b1, 1'b0,2,2, 1'b1,1'b1,1,1'b0,1'b1,1'b0};
    vecs[13] = '{1'b0,1'b0,1'b0, 1'b0,2,2, 1'b0,1'b1,0,1'b1,1'b1,1'b1};
    vecs[14] = '{1'b0,1'b0,1'b0, 1'b0,2,2, 1'b0,1'b1,0,1'b1,1'b1,1'b1};

    wdata = '0;
    sclr = 1'b1; push = 1'b0; pop = 1'b0; parity_err_in = 1'b0;
    tick();
    do_reset();

    // Reset state
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_used", used_words, 0);
    chk("rst_overflow", overflow, 0);
    tick();

    // Single push latency, pop, underflow, parity gating
    for (int v = 0; v < 15; v++) begin
      push = vecs[v].push; pop = vecs[v].pop; parity_err_in = vecs[v].par;
      #1;
      chk($sformatf("v%0d_mem_we", v), mem_we, vecs[v].we);
      chk($sformatf("v%0d_wraddr", v), mem_wraddr, vecs[v].wraddr);
      chk($sformatf("v%0d_rdaddr", v), mem_rdaddr, vecs[v].rdaddr);
      chk($sformatf("v%0d_out_valid", v), out_valid, vecs[v].ov);
      chk($sformatf("v%0d_in_ready", v), in_ready, vecs[v].rdy);
      chk($sformatf("v%0d_used", v), used_words, vecs[v].used);
      chk($sformatf("v%0d_empty", v), empty, vecs[v].emp);
      chk($sformatf("v%0d_underflow", v), underflow, vecs[v].uf);
      chk($sformatf("v%0d_parity", v), parity_err, vecs[v].pe);
      $display("vec %0d: push=%0b pop=%0b par=%0b we=%0b wa=%0d ra=%0d ov=%0b used=%0d",
               v, push, pop, parity_err_in, mem_we, mem_wraddr, mem_rdaddr, out_valid, used_words);
      tick();
    end
    push = 1'b0; pop = 1'b0; parity_err_in = 1'b0;

    // Pop straight after reset -> underflow only
    do_reset();
    pop = 1'b1;
    #1 chk("uf_rdaddr_pop", mem_rdaddr, 0);
    tick();
    pop = 1'b0;
    #1;
    chk("uf_flag", underflow, 1);
    chk("uf_used", used_words, 0);
    chk("uf_rdaddr", mem_rdaddr, 0);
    $display("underflow seq: uf=%0b used=%0d ra=%0d", underflow, used_words, mem_rdaddr);
    tick();

    // Fill to full, overflow, push+pop while full
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      push = 1'b1;
      #1 chk($sformatf("fill_wraddr%0d", i), mem_wraddr, i);
      tick();
    end
    #1;
    chk("full_flag", full, 1);
    chk("full_in_ready", in_ready, 0);
    chk("full_used", used_words, DEPTH);
    chk("full_mem_we", mem_we, 0);
    chk("full_wraddr_wrap", mem_wraddr, 0);
    tick();
    push = 1'b0;
    #1;
    chk("ovf_flag", overflow, 1);
    chk("ovf_used", used_words, DEPTH);
    $display("fill seq: full=%0b ovf=%0b used=%0d", full, overflow, used_words);
    wait_valid("full_wait_valid");
    tick();
    push = 1'b1; pop = 1'b1;
    #1 chk("fullpp_mem_we", mem_we, 0);
    tick();
    pop = 1'b0;
    #1;
    chk("fullpp_used", used_words, DEPTH - 1);
    chk("fullpp_full", full, 0);
    chk("after_mem_we", mem_we, 1);
    chk("after_wraddr", mem_wraddr, 0);
    tick();
    push = 1'b0;
    #1 chk("after_used", used_words, DEPTH);
    $display("full push+pop seq: used=%0d", used_words);
    tick();

    // Stream 100 words through the slice model
    do_reset();
    popped = 0; pushed = 0; bubbles = 0; seen_valid = 1'b0;
    for (int c = 0; c < 400 && popped < 100; c++) begin
      push  = (pushed < 100);
      wdata = word_of(pushed);
      pop   = out_valid;
      #1;
      if (out_valid) seen_valid = 1'b1;
      if (seen_valid && !out_valid && popped < 100) bubbles++;
      if (pop && out_valid) begin
        chk($sformatf("stream_data%0d", popped), slice_dout, word_of(popped));
        chk($sformatf("stream_rdaddr%0d", popped), mem_rdaddr, (popped + 1) % DEPTH);
        popped++;
      end
      if (push && mem_we) pushed++;
      tick();
    end
    push = 1'b0; pop = 1'b0;
    #1;
    chk("stream_pops", popped, 100);
    chk("stream_bubbles", bubbles, 0);
    chk("stream_overflow", overflow, 0);
    chk("stream_underflow", underflow, 0);
    chk("stream_used_end", used_words, 0);
    $display("stream seq: pushed=%0d popped=%0d bubbles=%0d", pushed, popped, bubbles);
    tick();

    // Parity on a popped word, then sclr with 10 entries held
    do_reset();
    for (int i = 0; i < 11; i++) begin
      push = 1'b1; tick();
    end
    push = 1'b0;
    wait_valid("sclr_wait_valid");
    pop = 1'b1; parity_err_in = 1'b1;
    tick();
    pop = 1'b0; parity_err_in = 1'b0;
    #1;
    chk("par_flag", parity_err, 1);
    chk("pre_sclr_used", used_words, 10);
    tick();
    sclr = 1'b1; push = 1'b1;
    #1 chk("sclr_mem_we", mem_we, 0);
    tick();
    sclr = 1'b0; push = 1'b0;
    #1;
    chk("sclr_used", used_words, 0);
    chk("sclr_out_valid", out_valid, 0);
    chk("sclr_empty", empty, 1);
    chk("sclr_in_ready", in_ready, 1);
    chk("sclr_parity", parity_err, 0);
    chk("sclr_wraddr", mem_wraddr, 0);
    chk("sclr_rdaddr", mem_rdaddr, 0);
    for (int i = 0; i < 6; i++) tick();
    #1 chk("sclr_no_late_valid", out_valid, 0);
    $display("sclr seq: used=%0d ov=%0b pe=%0b", used_words, out_valid, parity_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
